// File: rtl/updown_count_ctrl_if.sv
// Command handshake bundle between the control logic and the up/down counter sequencer.
interface updown_count_ctrl_if #(
  parameter int W  = 3,
  parameter int SW = 4
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [W-1:0]  cmd_lo;
  logic [W-1:0]  cmd_hi;
  logic [SW-1:0] cmd_sweeps;

  modport master (
    output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_sweeps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_sweeps,
    output cmd_ready
  );
endinterface

// File: rtl/updown_count_ctrl.sv
// Command sequencer for an external W-bit up/down counter: clears it, then steers
// direction and enable until the end value, optionally sweeping lo<->hi several times.
module updown_count_ctrl_checker #(
  parameter int SW = 4
) (
  input logic          clk,
  input logic          clr,
  input logic          cnt_en,
  input logic          cnt_clr,
  input logic          busy,
  input logic          done,
  input logic          err
);
  a_pulse_excl : assert property (@(posedge clk) disable iff (clr) !(done && err));
  a_en_busy    : assert property (@(posedge clk) disable iff (clr) cnt_en |-> busy);
  a_clr_no_en  : assert property (@(posedge clk) disable iff (clr) cnt_clr |-> !cnt_en);
endmodule

module updown_count_ctrl #(
  parameter int W  = 3,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          clr,
  updown_count_ctrl_if.slave cmd,
  input  logic          abort,
  input  logic [W-1:0]  cnt_q,
  output logic          cnt_m,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweep_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    mode_r;
  logic [W-1:0]  lo_r;
  logic [W-1:0]  hi_r;
  logic [SW-1:0] sweeps_r;
  logic [SW-1:0] sweep_cnt_r;
  logic          dir_r;
  logic          busy_r;
  logic          cnt_clr_r;
  logic          done_r;
  logic          err_r;

  logic          accept_s;
  logic          reject_s;
  logic          hit_s;
  logic          leg_step_s;
  logic          toggle_s;
  logic [W-1:0]  target_s;
  logic [SW-1:0] sweep_inc_s;

  // Ping-pong needs a non-empty range and at least one leg; mode 11 is never legal.
  function automatic logic cmd_illegal(
    input logic [1:0]    mode,
    input logic [W-1:0]  lo,
    input logic [W-1:0]  hi,
    input logic [SW-1:0] sweeps
  );
    logic bad;
    case (mode)
      MODE_RSV: bad = 1'b1;
      MODE_PP:  bad = (lo >= hi) || (sweeps == {SW{1'b0}});
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign target_s    = dir_r ? lo_r : hi_r;
  assign hit_s       = (cnt_q == target_s);
  assign sweep_inc_s = sweep_cnt_r + SW'(1);

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    leg_step_s  = 1'b0;
    toggle_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid && !abort) begin
          accept_s = 1'b1;
          if (cmd_illegal(cmd.cmd_mode, cmd.cmd_lo, cmd.cmd_hi, cmd.cmd_sweeps)) begin
            reject_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_CLR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_s) begin
          if (mode_r == MODE_PP) begin
            leg_step_s = 1'b1;
            if (sweep_inc_s == sweeps_r) begin
              state_nxt_s = ST_DONE;
            end else begin
              toggle_s    = 1'b1;
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched command, direction, leg counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      mode_r      <= 2'b00;
      lo_r        <= {W{1'b0}};
      hi_r        <= {W{1'b0}};
      sweeps_r    <= {SW{1'b0}};
      sweep_cnt_r <= {SW{1'b0}};
      dir_r       <= 1'b0;
      busy_r      <= 1'b0;
      cnt_clr_r   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s == ST_CLR) || (state_nxt_s == ST_RUN);
      cnt_clr_r <= (state_nxt_s == ST_CLR);
      done_r    <= (state_nxt_s == ST_DONE);
      err_r     <= reject_s;
      if (accept_s) begin
        mode_r   <= cmd.cmd_mode;
        lo_r     <= cmd.cmd_lo;
        hi_r     <= cmd.cmd_hi;
        sweeps_r <= cmd.cmd_sweeps;
      end
      if (state_r == ST_CLR) begin
        sweep_cnt_r <= {SW{1'b0}};
        dir_r       <= (mode_r == MODE_DOWN);
      end else begin
        if (leg_step_s) begin
          sweep_cnt_r <= sweep_inc_s;
        end
        if (toggle_s) begin
          dir_r <= ~dir_r;
        end
      end
    end
  end

  // Enable must drop in the very cycle abort or clr appears, so it stays combinational.
  assign cnt_en        = (state_r == ST_RUN) && !hit_s && !abort && !clr;
  assign cmd.cmd_ready = (state_r == ST_IDLE) && !abort;
  assign cnt_m         = dir_r;
  assign cnt_clr       = cnt_clr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign sweep_cnt     = sweep_cnt_r;

  updown_count_ctrl_checker #(.SW(SW)) u_chk (
    .clk     (clk),
    .clr     (clr),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Randomised scoreboard bench for updown_count_ctrl with a behavioural counter and reference model.
module tb_updown_count_ctrl;
  localparam int W  = 3;
  localparam int SW = 4;

  typedef struct {
    bit is_err;
    int q;
    int m;
    int sw;
    int en;
    int lat;
    int acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          abort = 1'b0;
  logic [W-1:0]  cnt_q = '0;
  logic          cnt_m, cnt_en, cnt_clr, busy, done, err;
  logic [SW-1:0] sweep_cnt;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  exp_t          sb[$];

  updown_count_ctrl_if #(.W(W), .SW(SW)) cif ();

  updown_count_ctrl #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd       (cif.slave),
    .abort     (abort),
    .cnt_q     (cnt_q),
    .cnt_m     (cnt_m),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External counter the controller drives.
  always @(posedge clk) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_m ? cnt_q - W'(1) : cnt_q + W'(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Outcome of a command derived from the command fields alone.
  function automatic exp_t model(input int mode, input int lo, input int hi, input int nsw);
    exp_t e;
    int   span;
    span = 1 << W;
    e = '{default: 0};
    if (mode == 3 || (mode == 2 && (lo >= hi || nsw == 0))) begin
      e.is_err = 1;
      e.lat    = 1;
      return e;
    end
    if (mode == 0) begin
      e.q = hi; e.m = 0; e.sw = 0; e.en = hi; e.lat = hi + 3;
    end else if (mode == 1) begin
      e.q = lo; e.m = 1; e.sw = 0; e.en = (span - lo) % span; e.lat = e.en + 3;
    end else begin
      e.q   = (nsw % 2 == 1) ? hi : lo;
      e.m   = (nsw - 1) % 2;
      e.sw  = nsw;
      e.en  = hi + (nsw - 1) * (hi - lo);
      e.lat = e.en + nsw + 2;
    end
    return e;
  endfunction

  // Called just after a falling edge; returns just after the falling edge of the CLR cycle.
  task automatic issue(input int mode, input int lo, input int hi, input int nsw,
                       input bit blk, input bit track, output int waited);
    exp_t e;
    cif.cmd_mode   = 2'(mode);
    cif.cmd_lo     = W'(lo);
    cif.cmd_hi     = W'(hi);
    cif.cmd_sweeps = SW'(nsw);
    cif.cmd_valid  = 1'b1;
    if (blk) begin
      abort = 1'b1;
      #1 chk("ready_blocked_by_abort", int'(cif.cmd_ready), 0);
      @(negedge clk);
      abort = 1'b0;
    end
    waited = 0;
    #1;
    while (!cif.cmd_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cif.cmd_ready) begin
      chk("accept_timeout", int'(cif.cmd_ready), 1);
      cif.cmd_valid = 1'b0;
      return;
    end
    e     = model(mode, lo, hi, nsw);
    e.acc = cyc;
    if (track) sb.push_back(e);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("clr_at_t1", int'(cnt_clr), e.is_err ? 0 : 1);
    chk("busy_at_t1", int'(busy), e.is_err ? 0 : 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || done) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("idle_timeout", int'(busy), 0);
  endtask

  // Monitor: counts enables per command and scores every done/err pulse.
  initial begin
    int   en = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cnt_clr) en = 0;
      else if (cnt_en) en++;
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'(done) + int'(err), 0);
        end else begin
          e = sb.pop_front();
          chk("err_pulse", int'(err), int'(e.is_err));
          chk("done_pulse", int'(done), e.is_err ? 0 : 1);
          chk("latency", cyc - e.acc, e.lat);
          if (!e.is_err) begin
            chk("final_cnt_q", int'(cnt_q), e.q);
            chk("final_cnt_m", int'(cnt_m), e.m);
            chk("sweep_cnt", int'(sweep_cnt), e.sw);
            chk("enable_count", en, e.en);
            chk("busy_with_done", int'(busy), 0);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int w;
    int k;
    cif.cmd_valid = 1'b0; cif.cmd_mode = 2'b00; cif.cmd_lo = '0; cif.cmd_hi = '0; cif.cmd_sweeps = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_cnt_m", int'(cnt_m), 0);
    chk("rst_done_err", int'(done) + int'(err), 0);
    chk("rst_sweep_cnt", int'(sweep_cnt), 0);
    clr = 1'b0;
    #1 chk("rst_ready", int'(cif.cmd_ready), 1);
    @(negedge clk);

    // Directed: up, down, ping-pong, rejects, trivial commands.
    issue(0, 0, 5, 0, 1'b0, 1'b1, w); wait_idle();
    issue(1, 3, 0, 0, 1'b0, 1'b1, w); wait_idle();
    issue(2, 2, 6, 3, 1'b0, 1'b1, w); wait_idle();
    issue(3, 1, 4, 2, 1'b0, 1'b1, w); wait_idle();
    issue(2, 5, 5, 2, 1'b0, 1'b1, w); wait_idle();
    issue(2, 1, 4, 0, 1'b0, 1'b1, w); wait_idle();
    issue(0, 0, 0, 0, 1'b0, 1'b1, w); wait_idle();
    issue(1, 0, 0, 0, 1'b0, 1'b1, w); wait_idle();
    issue(2, 0, 7, 2, 1'b1, 1'b1, w); wait_idle();

    // Abort mid-run at cnt_q=3, then immediate re-accept.
    issue(0, 0, 7, 0, 1'b0, 1'b0, w);
    k = 0;
    while (cnt_q != 3'd3 && k < 50) begin @(negedge clk); k++; end
    abort = 1'b1;
    #1 chk("abort_cnt_en", int'(cnt_en), 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_hold_q", int'(cnt_q), 3);
    chk("abort_no_done", int'(done), 0);
    issue(0, 0, 2, 0, 1'b0, 1'b1, w);
    chk("accept_after_abort", w, 0);
    wait_idle();

    // clr mid ping-pong with the next command held on the bus.
    issue(2, 1, 4, 5, 1'b0, 1'b0, w);
    cif.cmd_mode = 2'b00; cif.cmd_hi = W'(2); cif.cmd_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1 chk("held_not_ready", int'(cif.cmd_ready), 0);
    end
    chk("pre_clr_cnt_m", int'(cnt_m), 1);
    chk("pre_clr_sweep", int'(sweep_cnt), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_busy", int'(busy), 0);
    chk("clr_cnt_m", int'(cnt_m), 0);
    chk("clr_sweep", int'(sweep_cnt), 0);
    chk("clr_cnt_en_clr", int'(cnt_en) + int'(cnt_clr), 0);
    chk("clr_ready", int'(cif.cmd_ready), 1);
    begin
      exp_t e;
      e = model(0, 0, 2, 0);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    wait_idle();

    // Randomised commands.
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), 1'b1, w);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
